// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer with redirect, return-address stack and
// user-mode fetch legality flag.
module pc_sequencer #(
   parameter logic [15:0] RESET_VECTOR = 16'h0200,
   parameter logic [15:0] USER_BASE    = 16'h0400,
   parameter int          DEPTH        = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     J,
   input  logic [15:0]              J_R,
   input  logic                     Store_Current,
   input  logic                     reti,
   input  logic                     stall,
   input  logic [1:0]               Mode,
   output logic [15:0]              PC,
   output logic                     fetch_valid,
   output logic                     Illegal_PC_in,
   output logic [$clog2(DEPTH):0]   stack_depth,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      SEL_JUMP,
      SEL_POP,
      SEL_HOLD,
      SEL_INC
   } sel_t;

   sel_t           sel;
   logic [15:0]    stack_mem [DEPTH];
   logic [PW-1:0]  top;
   logic [PW-1:0]  top_m1;
   logic           push;
   logic           pop;
   logic           empty;
   logic           full;
   logic           unused_mode;

   // top points at the next free slot; when full it also addresses the oldest
   // entry, so a push while full overwrites it without extra logic.
   assign top_m1      = top - PW'(1);
   assign empty       = (stack_depth == '0);
   assign full        = (stack_depth == (PW+1)'(DEPTH));
   assign push        = J & Store_Current;
   assign pop         = reti & ~J & ~empty;
   assign unused_mode = Mode[0];

   assign Illegal_PC_in = fetch_valid & ~Mode[1] & (PC < USER_BASE);

   always_comb begin
      // NOTE: assign a default first so every path drives sel and no latch is inferred.
      sel = SEL_INC;
      if (J)
         sel = SEL_JUMP;
      else if (pop)
         sel = SEL_POP;
      else if (stall)
         sel = SEL_HOLD;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst) begin
         PC          <= RESET_VECTOR;
         fetch_valid <= 1'b0;
         stack_depth <= '0;
         top         <= '0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         underflow <= reti & ~J & empty;

         unique case (sel)
            SEL_JUMP: begin
               PC          <= J_R;
               fetch_valid <= 1'b0;
            end
            SEL_POP: begin
               PC          <= stack_mem[top_m1];
               fetch_valid <= 1'b0;
            end
            SEL_HOLD: begin
               PC          <= PC;
               fetch_valid <= fetch_valid;
            end
            SEL_INC: begin
               PC          <= PC + 16'd1;
               fetch_valid <= 1'b1;
            end
         endcase

         if (push) begin
            top <= top + PW'(1);
            if (full)
               overflow <= 1'b1;
            else
               stack_depth <= stack_depth + 1'b1;
         end else if (pop) begin
            top         <= top_m1;
            stack_depth <= stack_depth - 1'b1;
         end
      end
   end

   // NOTE: the stack array is deliberately not reset; depth gates every read,
   // so stale entries are never observed and the array can map to plain RAM.
   always_ff @(posedge clk) begin
      if (rst && push)
         stack_mem[top] <= PC;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, 16'h0200, PC loaded on reset.
REQ-002 Parameter USER_BASE, 16'h0400, lowest PC legal in user mode.
REQ-003 Parameter DEPTH, 4, return-address stack entries (power of two, 2..16).
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 J  input  1  redirect request from exception/branch monitor.
REQ-007 J_R  input  16  redirect target, valid when J=1.
REQ-008 Store_Current  input  1  push current PC as return address, qualified by J.
REQ-009 reti  input  1  return-from-exception instruction retiring this cycle.
REQ-010 stall  input  1  hold fetch PC.
REQ-011 Mode  input  2  current privilege mode; Mode[1]=1 is privileged.
REQ-012 PC  output  16  current fetch address (registered).
REQ-013 fetch_valid  output  1  PC is a live fetch, not a squash bubble (registered).
REQ-014 Illegal_PC_in  output  1  user-mode fetch below USER_BASE (combinational).
REQ-015 stack_depth  output  clog2(DEPTH)+1  live entry count (registered).
REQ-016 overflow  output  1  sticky, push occurred while full.
REQ-017 underflow  output  1  one-cycle pulse, reti with empty stack.

Function
REQ-018 Next-PC priority each cycle SHALL be: J, then reti with non-empty stack, then stall, then increment.
REQ-019 J=1 SHALL load PC<=J_R next cycle regardless of stall or reti.
REQ-020 J=1 with Store_Current=1 SHALL push the pre-update PC value onto the stack in the same cycle.
REQ-021 Store_Current=1 with J=0 SHALL be ignored (no push).
REQ-022 reti=1, J=0, depth>0 SHALL load PC<=top entry and decrement depth, regardless of stall.
REQ-023 reti=1, J=0, depth=0 SHALL not pop, SHALL pulse underflow for one cycle, and PC SHALL follow stall/increment rules.
REQ-024 reti=1 with J=1 SHALL be ignored entirely (no pop, no underflow).
REQ-025 Push when depth=DEPTH SHALL overwrite the oldest entry (circular), hold depth at DEPTH, and set overflow.
REQ-026 Increment SHALL be PC+1 modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-027 stall=1 without J or valid pop SHALL hold PC and fetch_valid unchanged.
REQ-028 fetch_valid SHALL be 0 the cycle after any PC load by J or pop, and 1 otherwise.
REQ-029 Illegal_PC_in SHALL equal fetch_valid & ~Mode[1] & (PC < USER_BASE), unsigned compare.
REQ-030 Stack storage SHALL be DEPTH x 16 bits with top pointer wrapping modulo DEPTH; entries are not cleared on pop.

Reset
REQ-031 rst=0 at a clock edge SHALL set PC=RESET_VECTOR, fetch_valid=0, depth=0, overflow=0, underflow=0, top pointer=0.
REQ-032 Reset SHALL override J, reti, stall and Store_Current on the same edge; storage contents are don't-care.
REQ-033 The first cycle after reset release SHALL increment from RESET_VECTOR unless stalled or redirected.

Verification
REQ-034 Reset, then 3 unstalled cycles -> PC 0200,0201,0202,0203; fetch_valid 0,1,1,1.
REQ-035 PC=0250, J=1, J_R=0030, Store_Current=1 -> PC=0030, fetch_valid=0, depth=1; then reti -> PC=0250, depth=0, fetch_valid=0.
REQ-036 Five J+Store_Current pushes from PCs A..E with DEPTH=4 -> overflow=1, depth=4; four retis return E,D,C,B; fifth reti pulses underflow, PC increments.
REQ-037 stall=1 with J=1, J_R=1234 -> PC=1234 next cycle; stall=1 alone -> PC holds for 5 cycles.
REQ-038 Mode=00, J_R=0100 -> Illegal_PC_in=0 while fetch_valid=0, then 1 next cycle; Mode=10 same sequence -> Illegal_PC_in stays 0.
REQ-039 PC=FFFF unstalled -> PC=0000; rst=0 mid-sequence with depth=3 -> PC=0200, depth=0, overflow=0 next cycle.
